apb_rr_arbiter: RTL and testbench

Two-requester round-robin arbiter that shares a single APB completer (an APB slave of the kind exercised by the equivalence bench) between two internal requesters. Each requester issues one read or write at a time over a simple valid/ready interface. The arbiter serialises them into legal APB SETUP/ACCESS sequences and routes PRDATA/PSLVERR back to the owner. It sits between the requester logic and the APB slave under test.

---
 rtl/apb_rr_arbiter.sv | 158 +++++++++++++++
 tb/tb_apb_rr_arbiter.sv | 455 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_rr_arbiter.sv
// apb_rr_arbiter
// Shares one APB completer between two internal requesters. Requests are
// arbitrated round-robin in IDLE, then driven through a SETUP/ACCESS pair.
// The completion strobe, read data and error are routed back to the owner.
//
// Handshake (requester side): reqN_valid rises with write/addr/wdata
// stable and stays high until the cycle in which reqN_ready=1. That ready
// cycle is the only completion: reqN_rdata/reqN_err are meaningful only
// while reqN_ready=1. At the edge that ends the ready cycle, the requester
// may drop valid or present its next transfer. The arbiter always returns
// to IDLE after a transfer, so a new request is arbitrated there.

module apb_rr_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  PCLK,
    input  logic                  PRESET,

    // requester 0
    input  logic                  req0_valid,
    input  logic                  req0_write,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    output logic                  req0_ready,
    output logic [DATA_WIDTH-1:0] req0_rdata,
    output logic                  req0_err,

    // requester 1
    input  logic                  req1_valid,
    input  logic                  req1_write,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    output logic                  req1_ready,
    output logic [DATA_WIDTH-1:0] req1_rdata,
    output logic                  req1_err,

    // APB requester port
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic                  PREADY,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PSLVERR,

    // current FSM state, for checkers and waveform debug
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t state;
    logic   owner;       // requester that owns the transfer in flight
    logic   last_grant;  // requester granted most recently; loses the next tie

    logic   any_valid;
    logic   grant_sel;
    logic   access_done;

    // Round-robin choice among the requesters valid this cycle.
    always_comb begin
        any_valid = req0_valid | req1_valid;
        grant_sel = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_sel = ~last_grant;
        end else if (req1_valid) begin
            grant_sel = 1'b1;
        end
    end

    // Single FSM: sequencing, ownership and all registered APB outputs.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            PSEL       <= 1'b0;
            PENABLE    <= 1'b0;
            PWRITE     <= 1'b0;
            PADDR      <= '0;
            PWDATA     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        state      <= SETUP;
                        owner      <= grant_sel;
                        last_grant <= grant_sel;
                        PSEL       <= 1'b1;
                        PENABLE    <= 1'b0;
                        if (grant_sel) begin
                            PWRITE <= req1_write;
                            PADDR  <= req1_addr;
                            PWDATA <= req1_wdata;
                        end else begin
                            PWRITE <= req0_write;
                            PADDR  <= req0_addr;
                            PWDATA <= req0_wdata;
                        end
                    end
                end
                SETUP: begin
                    state   <= ACCESS;
                    PENABLE <= 1'b1;
                end
                ACCESS: begin
                    // PSLVERR does not alter sequencing; only PREADY ends ACCESS
                    if (PREADY) begin
                        state   <= IDLE;
                        PSEL    <= 1'b0;
                        PENABLE <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    PSEL    <= 1'b0;
                    PENABLE <= 1'b0;
                end
            endcase
        end
    end

    // Completion routing: strobe to the owner only, data/error passed through.
    always_comb begin
        access_done = (state == ACCESS) && PREADY;
        req0_ready  = access_done && (owner == 1'b0);
        req1_ready  = access_done && (owner == 1'b1);
        req0_rdata  = PRDATA;
        req1_rdata  = PRDATA;
        req0_err    = PSLVERR;
        req1_err    = PSLVERR;
        dbg_state   = state;
    end

    // SETUP always advances to ACCESS unless reset intervenes.
    a_setup_to_access: assert property (@(posedge PCLK)
        (PSEL && !PENABLE && !PRESET) |=> (PSEL && PENABLE));

    // Transfer attributes hold for the whole SETUP/ACCESS window.
    a_fields_stable: assert property (@(posedge PCLK)
        (PSEL && !(PENABLE && PREADY) && !PRESET) |=>
            (PSEL && $stable(PADDR) && $stable(PWDATA) && $stable(PWRITE)));

    // IDLE is always visited after a completed transfer.
    a_idle_after_done: assert property (@(posedge PCLK)
        (PSEL && PENABLE && PREADY && !PRESET) |=> !PSEL);

    // At most one requester is ever told it completed.
    a_one_hot_ready: assert property (@(posedge PCLK)
        !(req0_ready && req1_ready));

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Bench for apb_rr_arbiter: a small APB completer model with programmable
// wait states and error address, queue-fed requester drivers, and a
// per-requester expected-response scoreboard.

module tb_apb_rr_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    // ---------------- clock / reset ----------------
    logic PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    logic          PRESET;
    logic          req0_valid, req0_write, req1_valid, req1_write;
    logic [AW-1:0] req0_addr, req1_addr;
    logic [DW-1:0] req0_wdata, req1_wdata;
    logic          req0_ready, req1_ready, req0_err, req1_err;
    logic [DW-1:0] req0_rdata, req1_rdata;
    logic          PSEL, PENABLE, PWRITE;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA;
    logic          PREADY, PSLVERR;
    logic [DW-1:0] PRDATA;
    logic [1:0]    dbg_state;

    apb_rr_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_ready(req0_ready), .req0_rdata(req0_rdata),
        .req0_err(req0_err),
        .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_ready(req1_ready), .req1_rdata(req1_rdata),
        .req1_err(req1_err),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR),
        .dbg_state(dbg_state)
    );

    // ---------------- APB completer model ----------------
    int            wait_cfg = 0;
    logic          err_en   = 1'b0;
    logic [AW-1:0] err_addr = '0;
    logic [3:0]    wcnt;

    function automatic logic [DW-1:0] rd_model(input logic [AW-1:0] a);
        if (a == 32'h10) return 32'hDEAD_BEEF;
        return {a[15:0], ~a[15:0]};
    endfunction

    assign PREADY  = PSEL && PENABLE && (32'(wcnt) == wait_cfg);
    assign PRDATA  = rd_model(PADDR);
    assign PSLVERR = PREADY && err_en && (PADDR == err_addr);

    always @(posedge PCLK) begin
        if (PRESET || !(PSEL && PENABLE) || PREADY) wcnt <= '0;
        else wcnt <= wcnt + 4'd1;
    end

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic          write;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } cmd_t;

    cmd_t          cmd_q0[$];
    cmd_t          cmd_q1[$];
    logic [DW:0]   exp_q0[$];   // {err, rdata}
    logic [DW:0]   exp_q1[$];
    logic          grant_log[$];
    int            n_cmp = 0;
    int            n_err = 0;
    logic          done0 = 1'b0;
    logic          done1 = 1'b0;
    logic          rst_req = 1'b1;

    always @(negedge PCLK) begin
        logic [DW:0] e;
        if (req0_ready === 1'b1) begin
            grant_log.push_back(1'b0);
            n_cmp++;
            if (exp_q0.size() == 0) begin
                n_err++;
                $display("FAIL sb_req0_unexpected: got ready=1 want no strobe");
            end else begin
                e = exp_q0.pop_front();
                if ({req0_err, req0_rdata} !== e) begin
                    n_err++;
                    $display("FAIL sb_req0_resp: got err=%b rdata=%h want err=%b rdata=%h",
                             req0_err, req0_rdata, e[DW], e[DW-1:0]);
                end
            end
        end
        if (req1_ready === 1'b1) begin
            grant_log.push_back(1'b1);
            n_cmp++;
            if (exp_q1.size() == 0) begin
                n_err++;
                $display("FAIL sb_req1_unexpected: got ready=1 want no strobe");
            end else begin
                e = exp_q1.pop_front();
                if ({req1_err, req1_rdata} !== e) begin
                    n_err++;
                    $display("FAIL sb_req1_resp: got err=%b rdata=%h want err=%b rdata=%h",
                             req1_err, req1_rdata, e[DW], e[DW-1:0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic issue(input int n, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
        cmd_t        c;
        logic [DW:0] e;
        c = {w, a, d};
        e = {(err_en && (a == err_addr)), rd_model(a)};
        if (n == 0) begin
            cmd_q0.push_back(c);
            exp_q0.push_back(e);
        end else begin
            cmd_q1.push_back(c);
            exp_q1.push_back(e);
        end
    endtask

    // One clock cycle: retire completed commands, drive heads, sample ready.
    task automatic cycle();
        @(posedge PCLK);
        #1;
        PRESET = rst_req;
        if (done0 && cmd_q0.size() > 0) cmd_q0.delete(0);
        if (done1 && cmd_q1.size() > 0) cmd_q1.delete(0);
        if (cmd_q0.size() > 0) begin
            req0_valid = 1'b1;
            req0_write = cmd_q0[0].write;
            req0_addr  = cmd_q0[0].addr;
            req0_wdata = cmd_q0[0].wdata;
        end else begin
            req0_valid = 1'b0;
        end
        if (cmd_q1.size() > 0) begin
            req1_valid = 1'b1;
            req1_write = cmd_q1[0].write;
            req1_addr  = cmd_q1[0].addr;
            req1_wdata = cmd_q1[0].wdata;
        end else begin
            req1_valid = 1'b0;
        end
        @(negedge PCLK);
        #1;
        done0 = req0_ready;
        done1 = req1_ready;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_req = 1'b1;
        repeat (3) cycle();
        n_cmp++;
        if ({PSEL, PENABLE, PWRITE} !== 3'b000) begin
            n_err++;
            $display("FAIL rst_ctrl: got psel/pen/pwr=%b want 000", {PSEL, PENABLE, PWRITE});
        end
        n_cmp++;
        if (PADDR !== '0 || PWDATA !== '0) begin
            n_err++;
            $display("FAIL rst_bus: got paddr=%h pwdata=%h want 0/0", PADDR, PWDATA);
        end
        rst_req = 1'b0;
        cycle();
        n_cmp++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            n_err++;
            $display("FAIL rst_ready: got %b want 00", {req0_ready, req1_ready});
        end
        n_cmp++;
        if (dbg_state !== 2'd0 || PSEL !== 1'b0) begin
            n_err++;
            $display("FAIL rst_idle: got state=%0d psel=%b want 0/0", dbg_state, PSEL);
        end
    endtask

    task automatic test_single_read();
        wait_cfg = 0;
        issue(0, 1'b0, 32'h10, 32'h0);
        cycle();  // C: request visible, still IDLE
        n_cmp++;
        if (PSEL !== 1'b0 || dbg_state !== 2'd0) begin
            n_err++;
            $display("FAIL sr_c: got psel=%b state=%0d want 0/0", PSEL, dbg_state);
        end
        cycle();  // C+1: SETUP
        n_cmp++;
        if ({PSEL, PENABLE} !== 2'b10 || PADDR !== 32'h10 || PWRITE !== 1'b0) begin
            n_err++;
            $display("FAIL sr_setup: got sel/en=%b addr=%h wr=%b want 10/00000010/0",
                     {PSEL, PENABLE}, PADDR, PWRITE);
        end
        cycle();  // C+2: ACCESS with strobe
        n_cmp++;
        if ({PSEL, PENABLE} !== 2'b11 || req0_ready !== 1'b1 || req0_rdata !== 32'hDEAD_BEEF) begin
            n_err++;
            $display("FAIL sr_access: got sel/en=%b rdy=%b rdata=%h want 11/1/deadbeef",
                     {PSEL, PENABLE}, req0_ready, req0_rdata);
        end
        n_cmp++;
        if (req1_ready !== 1'b0) begin
            n_err++;
            $display("FAIL sr_other: got req1_ready=%b want 0", req1_ready);
        end
        cycle();  // C+3: back to IDLE
        n_cmp++;
        if (PSEL !== 1'b0 || dbg_state !== 2'd0 || exp_q0.size() != 0) begin
            n_err++;
            $display("FAIL sr_idle: got psel=%b state=%0d pending=%0d want 0/0/0",
                     PSEL, dbg_state, exp_q0.size());
        end
    endtask

    task automatic test_wait_write();
        int psel_n = 0;
        wait_cfg = 3;
        issue(1, 1'b1, 32'h24, 32'h0000_00A5);
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (PSEL === 1'b1) begin
                psel_n++;
                n_cmp++;
                if (PADDR !== 32'h24 || PWDATA !== 32'hA5 || PWRITE !== 1'b1 ||
                    PENABLE !== (psel_n >= 2)) begin
                    n_err++;
                    $display("FAIL ww_fields: got addr=%h wdata=%h wr=%b en=%b want 24/a5/1/%b",
                             PADDR, PWDATA, PWRITE, PENABLE, (psel_n >= 2));
                end
            end
            n_cmp++;
            if (req1_ready !== (psel_n == 5 && PSEL === 1'b1)) begin
                n_err++;
                $display("FAIL ww_ready: got %b at psel cycle %0d want %b",
                         req1_ready, psel_n, (psel_n == 5 && PSEL === 1'b1));
            end
        end
        n_cmp++;
        if (psel_n != 5) begin
            n_err++;
            $display("FAIL ww_len: got %0d psel cycles want 5", psel_n);
        end
        wait_cfg = 0;
    endtask

    task automatic test_contention();
        int budget = 60;
        int gap = 0;
        logic started = 1'b0;
        rst_req = 1'b1;
        repeat (2) cycle();
        rst_req = 1'b0;
        wait_cfg = 0;
        grant_log.delete();
        for (int i = 0; i < 4; i++) begin
            issue(0, 1'($urandom_range(0, 1)), 32'h100 + 32'(i * 4), $urandom);
            issue(1, 1'($urandom_range(0, 1)), 32'h200 + 32'(i * 4), $urandom);
        end
        while ((cmd_q0.size() > 0 || cmd_q1.size() > 0) && budget > 0) begin
            cycle();
            budget--;
            if (PSEL === 1'b1) begin
                if (started && gap > 0) begin
                    n_cmp++;
                    if (gap != 1) begin
                        n_err++;
                        $display("FAIL ct_gap: got %0d idle cycles want 1", gap);
                    end
                end
                gap = 0;
                started = 1'b1;
            end else if (started) begin
                gap++;
            end
        end
        n_cmp++;
        if (budget == 0) begin
            n_err++;
            $display("FAIL ct_timeout: got pending %0d/%0d want 0/0", cmd_q0.size(), cmd_q1.size());
        end
        n_cmp++;
        if (grant_log.size() != 8) begin
            n_err++;
            $display("FAIL ct_count: got %0d grants want 8", grant_log.size());
        end
        for (int i = 0; i < grant_log.size(); i++) begin
            n_cmp++;
            if (grant_log[i] !== (i % 2 == 1)) begin
                n_err++;
                $display("FAIL ct_order: grant %0d got req%0d want req%0d", i, grant_log[i], i % 2);
            end
        end
    endtask

    task automatic test_error();
        logic seen;
        err_en   = 1'b1;
        err_addr = 32'h40;
        wait_cfg = 1;
        issue(0, 1'b0, 32'h40, 32'h0);
        issue(0, 1'b0, 32'h44, 32'h0);
        for (int k = 0; k < 2; k++) begin
            seen = 1'b0;
            for (int i = 0; i < 10 && !seen; i++) begin
                cycle();
                n_cmp++;
                if (req1_ready !== 1'b0) begin
                    n_err++;
                    $display("FAIL er_other: got req1_ready=%b want 0", req1_ready);
                end
                if (req0_ready === 1'b1) begin
                    seen = 1'b1;
                    n_cmp++;
                    if (req0_err !== (k == 0)) begin
                        n_err++;
                        $display("FAIL er_flag: transfer %0d got err=%b want %b", k, req0_err, (k == 0));
                    end
                end
            end
            n_cmp++;
            if (!seen) begin
                n_err++;
                $display("FAIL er_timeout: transfer %0d got no ready want ready", k);
            end
        end
        cycle();
        err_en   = 1'b0;
        wait_cfg = 0;
    endtask

    task automatic test_reset_mid();
        int budget = 10;
        wait_cfg = 10;
        issue(0, 1'b1, 32'h80, 32'h1234_5678);
        while (!(PSEL === 1'b1 && PENABLE === 1'b1) && budget > 0) begin
            cycle();
            budget--;
        end
        n_cmp++;
        if (budget == 0) begin
            n_err++;
            $display("FAIL rm_timeout: got no ACCESS want ACCESS");
        end
        cycle();              // second ACCESS cycle, PREADY low
        rst_req = 1'b1;
        cycle();              // reset asserted during ACCESS
        n_cmp++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            n_err++;
            $display("FAIL rm_strobe: got %b want 00", {req0_ready, req1_ready});
        end
        cycle();              // first cycle after the reset edge
        n_cmp++;
        if ({PSEL, PENABLE, PWRITE} !== 3'b000 || PADDR !== '0 || PWDATA !== '0 ||
            dbg_state !== 2'd0) begin
            n_err++;
            $display("FAIL rm_regs: got ctl=%b addr=%h wdata=%h state=%0d want 000/0/0/0",
                     {PSEL, PENABLE, PWRITE}, PADDR, PWDATA, dbg_state);
        end
        n_cmp++;
        if (exp_q0.size() != 1) begin
            n_err++;
            $display("FAIL rm_aborted: got %0d pending want 1", exp_q0.size());
        end
        exp_q0.delete();
        cmd_q0.delete();
        done0 = 1'b0;
        wait_cfg = 0;
        grant_log.delete();
        issue(1, 1'b0, 32'h300, 32'h0);
        issue(0, 1'b0, 32'h310, 32'h0);
        rst_req = 1'b0;
        cycle();              // both valid, IDLE
        cycle();              // SETUP for the tie winner
        n_cmp++;
        if (PSEL !== 1'b1 || PADDR !== 32'h310) begin
            n_err++;
            $display("FAIL rm_tie: got psel=%b addr=%h want 1/00000310", PSEL, PADDR);
        end
        budget = 20;
        while ((cmd_q0.size() > 0 || cmd_q1.size() > 0) && budget > 0) begin
            cycle();
            budget--;
        end
        n_cmp++;
        if (grant_log.size() != 2 || grant_log[0] !== 1'b0 || grant_log[1] !== 1'b1) begin
            n_err++;
            $display("FAIL rm_order: got %0d grants want req0 then req1", grant_log.size());
        end
    endtask

    task automatic test_back_to_back();
        int budget = 20;
        int cyc = 0;
        int last = -1;
        wait_cfg = 0;
        grant_log.delete();
        for (int i = 0; i < 3; i++)
            issue(0, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)) << 2, $urandom);
        while (cmd_q0.size() > 0 && budget > 0) begin
            cycle();
            budget--;
            cyc++;
            if (req0_ready === 1'b1) begin
                if (last >= 0) begin
                    n_cmp++;
                    if (cyc - last != 3) begin
                        n_err++;
                        $display("FAIL bb_cadence: got %0d cycles want 3", cyc - last);
                    end
                end
                last = cyc;
            end
        end
        n_cmp++;
        if (grant_log.size() != 3 || grant_log[0] !== 1'b0 || grant_log[1] !== 1'b0 ||
            grant_log[2] !== 1'b0) begin
            n_err++;
            $display("FAIL bb_grants: got %0d grants want 3 to req0", grant_log.size());
        end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        PRESET     = 1'b1;
        req0_valid = 1'b0; req0_write = 1'b0; req0_addr = '0; req0_wdata = '0;
        req1_valid = 1'b0; req1_write = 1'b0; req1_addr = '0; req1_wdata = '0;
        test_reset();
        test_single_read();
        test_wait_write();
        test_contention();
        test_error();
        test_reset_mid();
        test_back_to_back();
        repeat (2) cycle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        n_err++;
        $display("FAIL watchdog: got no completion want finish before 200000");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog expired");
    end

endmodule
